// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder and push-switch front end: synchronize, debounce, decode detents into pulses.
// Latency is 2 + DEB_CYCLES + 1 cycles from a stable pin edge to its pulse; there is no backpressure.
module rotary_decoder #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic sw_n,
  output logic cw,
  output logic ccw,
  output logic btn,
  output logic err
);

  // Quadrature states as {A,B}; clockwise order is DET -> QA -> QAB -> QB -> DET.
  localparam logic [1:0] Q_DET = 2'b11;
  localparam logic [1:0] Q_A   = 2'b01;
  localparam logic [1:0] Q_AB  = 2'b00;
  localparam logic [1:0] Q_B   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Bit 2 = A, bit 1 = B, bit 0 = switch.
  logic [2:0]       meta;
  logic [2:0]       sync;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [CNT_W-1:0] cnt [3];

  logic signed [3:0] acc;
  logic signed [3:0] acc_nx;
  logic [1:0]        q_cur;
  logic [1:0]        q_old;
  logic              step_cw;
  logic              step_ccw;
  logic              skip;
  logic              entering;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 3'b111;
      sync <= 3'b111;
    end else begin
      meta <= {enc_a, enc_b, sw_n};
      sync <= meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // deb_q lags deb by one cycle so every debounced change is seen exactly once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q <= 3'b111;
    end else begin
      deb_q <= deb;
    end
  end

  assign q_cur    = deb[2:1];
  assign q_old    = deb_q[2:1];
  assign entering = (q_cur == Q_DET) && (q_old != Q_DET);

  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    skip     = 1'b0;
    case ({q_old, q_cur})
      {Q_DET, Q_A}, {Q_A, Q_AB}, {Q_AB, Q_B}, {Q_B, Q_DET}: step_cw  = 1'b1;
      {Q_DET, Q_B}, {Q_B, Q_AB}, {Q_AB, Q_A}, {Q_A, Q_DET}: step_ccw = 1'b1;
      {Q_DET, Q_AB}, {Q_AB, Q_DET}, {Q_A, Q_B}, {Q_B, Q_A}: skip     = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_nx = acc;
    if (step_cw && (acc != 4'sd4)) begin
      acc_nx = acc + 4'sd1;
    end else if (step_ccw && (acc != -4'sd4)) begin
      acc_nx = acc - 4'sd1;
    end
  end

  // A detent only counts when all four single steps were seen in one direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cw  <= 1'b0;
      ccw <= 1'b0;
      btn <= 1'b0;
      err <= 1'b0;
    end else begin
      cw  <= entering && (acc_nx == 4'sd4);
      ccw <= entering && (acc_nx == -4'sd4);
      err <= skip;
      btn <= deb_q[0] && !deb[0];
      acc <= entering ? 4'sd0 : acc_nx;
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder with DEB_CYCLES=4: directed scenarios plus random pin activity against a window-based model.
module tb_rotary_decoder;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic sw_n  = 1'b1;
  logic cw, ccw, btn, err;

  int vectors = 0;
  int fails   = 0;

  rotary_decoder #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .sw_n(sw_n),
    .cw(cw), .ccw(ccw), .btn(btn), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a debounced level changes once the last DEB synchronized samples
  // (pins delayed two edges, forced high just after reset) all disagree with it.
  int cyc = 0;
  bit seen_rst = 0;
  logic [2:0] m_deb = 3'b111, m_prev = 3'b111;
  int m_acc = 0;
  logic m_cw = 0, m_ccw = 0, m_btn = 0, m_err = 0;
  int mcw = 0, mccw = 0, mbtn = 0, merr = 0;
  logic [2:0] pin_hist[$];
  logic [2:0] win[$];
  int since = 0;

  function automatic int qpos(logic [1:0] s);
    case (s)
      2'b11: return 0;
      2'b01: return 1;
      2'b00: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] o, n;
    logic [2:0] h;
    int d;
    bit all;
    cyc++;
    if (!rst_n) begin
      seen_rst = 1;
      m_deb = 3'b111; m_prev = 3'b111; m_acc = 0;
      m_cw = 0; m_ccw = 0; m_btn = 0; m_err = 0;
      pin_hist.delete(); win.delete(); since = 0;
    end else begin
      o = m_prev[2:1];
      n = m_deb[2:1];
      d = (qpos(n) - qpos(o) + 4) % 4;
      m_cw = 0; m_ccw = 0;
      m_err = (d == 2);
      if (d == 1 && m_acc < 4) m_acc++;
      if (d == 3 && m_acc > -4) m_acc--;
      if (n == 2'b11 && o != 2'b11) begin
        m_cw  = (m_acc == 4);
        m_ccw = (m_acc == -4);
        m_acc = 0;
      end
      m_btn = m_prev[0] && !m_deb[0];
      if (m_cw) mcw++;
      if (m_ccw) mccw++;
      if (m_btn) mbtn++;
      if (m_err) merr++;
      m_prev = m_deb;
      pin_hist.push_back({enc_a, enc_b, sw_n});
      if (pin_hist.size() > 3) void'(pin_hist.pop_front());
      h = (since < 2) ? 3'b111 : pin_hist[pin_hist.size() - 3];
      since++;
      win.push_back(h);
      if (win.size() > DEB) void'(win.pop_front());
      if (win.size() == DEB) begin
        for (int i = 0; i < 3; i++) begin
          all = 1;
          foreach (win[k]) if (win[k][i] == m_deb[i]) all = 0;
          if (all) m_deb[i] = ~m_deb[i];
        end
      end
    end
  end

  // Observed activity, sampled on the falling edge.
  int dcw = 0, dccw = 0, dbtn = 0, derr = 0, both = 0, mis = 0;
  int last_cw = 0, last_ccw = 0, last_btn = 0;
  always @(negedge clk) begin
    if (seen_rst) begin
      if ({cw, ccw, btn, err} !== {m_cw, m_ccw, m_btn, m_err}) mis++;
      if (cw === 1'b1) begin dcw++; last_cw = cyc; end
      if (ccw === 1'b1) begin dccw++; last_ccw = cyc; end
      if (btn === 1'b1) begin dbtn++; last_btn = cyc; end
      if (err === 1'b1) derr++;
      if (cw === 1'b1 && ccw === 1'b1) both++;
    end
  end

  int t_mark = 0;
  logic [1:0] cw_seq [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] ccw_seq[4] = '{2'b10, 2'b00, 2'b01, 2'b11};

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(logic [1:0] v, int n);
    enc_a = v[1];
    enc_b = v[0];
    t_mark = cyc;
    hold(n);
  endtask

  task automatic test_reset;
    int p0;
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; sw_n = 1'b1;
    hold(3);
    vectors++; if (cw !== 1'b0)  begin fails++; $display("FAIL reset_cw got %b want 0", cw); end
    vectors++; if (ccw !== 1'b0) begin fails++; $display("FAIL reset_ccw got %b want 0", ccw); end
    vectors++; if (btn !== 1'b0) begin fails++; $display("FAIL reset_btn got %b want 0", btn); end
    vectors++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    p0 = dcw + dccw + dbtn + derr;
    rst_n = 1'b1;
    hold(20);
    vectors++; if (dcw + dccw + dbtn + derr - p0 !== 0) begin
      fails++; $display("FAIL idle_pulses got %0d want 0", dcw + dccw + dbtn + derr - p0); end
  endtask

  task automatic test_cw;
    int c0 = dcw, a0 = dccw, e0 = derr, m0 = mis;
    foreach (cw_seq[i]) drive_ab(cw_seq[i], 10);
    hold(10);
    vectors++; if (dcw - c0 !== 1)  begin fails++; $display("FAIL cw_count got %0d want 1", dcw - c0); end
    vectors++; if (dccw - a0 !== 0) begin fails++; $display("FAIL cw_ccw_count got %0d want 0", dccw - a0); end
    vectors++; if (derr - e0 !== 0) begin fails++; $display("FAIL cw_err_count got %0d want 0", derr - e0); end
    vectors++; if (last_cw - t_mark !== 7) begin fails++; $display("FAIL cw_latency got %0d want 7", last_cw - t_mark); end
    vectors++; if (mis - m0 !== 0)  begin fails++; $display("FAIL cw_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_ccw;
    int c0 = dcw, a0 = dccw, m0 = mis;
    foreach (ccw_seq[i]) drive_ab(ccw_seq[i], 10);
    hold(10);
    vectors++; if (dccw - a0 !== 1) begin fails++; $display("FAIL ccw_count got %0d want 1", dccw - a0); end
    vectors++; if (dcw - c0 !== 0)  begin fails++; $display("FAIL ccw_cw_count got %0d want 0", dcw - c0); end
    vectors++; if (last_ccw - t_mark !== 7) begin fails++; $display("FAIL ccw_latency got %0d want 7", last_ccw - t_mark); end
    vectors++; if (mis - m0 !== 0)  begin fails++; $display("FAIL ccw_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_button;
    int b0 = dbtn, m0 = mis, mk;
    sw_n = 1'b0; hold(3);
    sw_n = 1'b1; hold(2);
    sw_n = 1'b0; mk = cyc; hold(20);
    sw_n = 1'b1; hold(20);
    vectors++; if (dbtn - b0 !== 1) begin fails++; $display("FAIL btn_count got %0d want 1", dbtn - b0); end
    vectors++; if (last_btn - mk !== 7) begin fails++; $display("FAIL btn_latency got %0d want 7", last_btn - mk); end
    vectors++; if (mis - m0 !== 0)  begin fails++; $display("FAIL btn_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_skip;
    int c0 = dcw, a0 = dccw, e0 = derr, m0 = mis;
    drive_ab(2'b00, 10);
    vectors++; if (derr - e0 !== 1) begin fails++; $display("FAIL skip_err got %0d want 1", derr - e0); end
    vectors++; if (dcw - c0 + dccw - a0 !== 0) begin fails++; $display("FAIL skip_detent got %0d want 0", dcw - c0 + dccw - a0); end
    drive_ab(2'b11, 10);
    vectors++; if (derr - e0 !== 2) begin fails++; $display("FAIL skip_return_err got %0d want 2", derr - e0); end
    foreach (cw_seq[i]) drive_ab(cw_seq[i], 10);
    hold(10);
    vectors++; if (dcw - c0 !== 1) begin fails++; $display("FAIL skip_then_cw got %0d want 1", dcw - c0); end
    vectors++; if (mis - m0 !== 0) begin fails++; $display("FAIL skip_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_reset_mid;
    int c0, a0, m0 = mis;
    drive_ab(2'b01, 10);
    drive_ab(2'b00, 10);
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
    hold(2);
    rst_n = 1'b1;
    hold(10);
    c0 = dcw; a0 = dccw;
    foreach (ccw_seq[i]) drive_ab(ccw_seq[i], 10);
    hold(10);
    vectors++; if (dccw - a0 !== 1) begin fails++; $display("FAIL rstmid_ccw got %0d want 1", dccw - a0); end
    vectors++; if (dcw - c0 !== 0)  begin fails++; $display("FAIL rstmid_cw got %0d want 0", dcw - c0); end
    vectors++; if (mis - m0 !== 0)  begin fails++; $display("FAIL rstmid_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_jitter;
    int p0 = dcw + dccw + derr;
    repeat (5) begin
      drive_ab(2'b01, 10);
      drive_ab(2'b11, 10);
    end
    vectors++; if (dcw + dccw + derr - p0 !== 0) begin
      fails++; $display("FAIL jitter_pulses got %0d want 0", dcw + dccw + derr - p0); end
  endtask

  task automatic test_reset_sw_low;
    int b0 = dbtn, mk;
    sw_n = 1'b0; rst_n = 1'b0;
    hold(3);
    rst_n = 1'b1; mk = cyc;
    hold(40);
    vectors++; if (dbtn - b0 !== 1) begin fails++; $display("FAIL rstsw_btn got %0d want 1", dbtn - b0); end
    vectors++; if (last_btn - mk !== 7) begin fails++; $display("FAIL rstsw_latency got %0d want 7", last_btn - mk); end
    sw_n = 1'b1;
    hold(10);
  endtask

  task automatic test_back_to_back;
    int c0 = dcw, m0 = mis;
    repeat (2) foreach (cw_seq[i]) drive_ab(cw_seq[i], DEB + 1);
    hold(10);
    vectors++; if (dcw - c0 !== 2) begin fails++; $display("FAIL b2b_cw got %0d want 2", dcw - c0); end
    vectors++; if (mis - m0 !== 0) begin fails++; $display("FAIL b2b_model got %0d bad cycles want 0", mis - m0); end
  endtask

  task automatic test_random;
    logic [1:0] ring[4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    int idx = 0, r;
    int m0 = mis, b0 = both;
    int c0 = dcw, a0 = dccw, k0 = dbtn, e0 = derr;
    int mc0 = mcw, ma0 = mccw, mk0 = mbtn, me0 = merr;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 9);
      if (r < 6) idx = (idx + (($urandom_range(0, 1) == 0) ? 1 : 3)) % 4;
      else if (r == 9) idx = $urandom_range(0, 3);
      enc_a = ring[idx][1];
      enc_b = ring[idx][0];
      if ($urandom_range(0, 3) == 0) sw_n = ~sw_n;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        hold($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      hold($urandom_range(1, 12));
    end
    enc_a = 1'b1; enc_b = 1'b1; sw_n = 1'b1;
    hold(20);
    vectors++; if (mis - m0 !== 0) begin fails++; $display("FAIL rand_model got %0d bad cycles want 0", mis - m0); end
    vectors++; if (both - b0 !== 0) begin fails++; $display("FAIL rand_cw_ccw_together got %0d want 0", both - b0); end
    vectors++; if (dcw - c0 !== mcw - mc0) begin fails++; $display("FAIL rand_cw got %0d want %0d", dcw - c0, mcw - mc0); end
    vectors++; if (dccw - a0 !== mccw - ma0) begin fails++; $display("FAIL rand_ccw got %0d want %0d", dccw - a0, mccw - ma0); end
    vectors++; if (dbtn - k0 !== mbtn - mk0) begin fails++; $display("FAIL rand_btn got %0d want %0d", dbtn - k0, mbtn - mk0); end
    vectors++; if (derr - e0 !== merr - me0) begin fails++; $display("FAIL rand_err got %0d want %0d", derr - e0, merr - me0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_cw;
    test_ccw;
    test_button;
    test_skip;
    test_reset_mid;
    test_jitter;
    test_reset_sw_low;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles needed before a debounced input changes; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: debounce counter width; SHALL hold DEB_CYCLES.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enc_a  input  1  encoder channel A, asynchronous, idle high.
REQ-006 enc_b  input  1  encoder channel B, asynchronous, idle high.
REQ-007 sw_n  input  1  encoder push switch, asynchronous, active-low (0 = pressed).
REQ-008 cw  output  1  one-cycle pulse per completed clockwise detent; drives the display stage's cw.
REQ-009 ccw  output  1  one-cycle pulse per completed counter-clockwise detent; drives the display stage's ccw.
REQ-010 btn  output  1  one-cycle pulse per debounced press; drives the display stage's btn.
REQ-011 err  output  1  one-cycle pulse when a debounced A/B change skips a quadrature state.

Function
REQ-012 Each of enc_a, enc_b, sw_n SHALL pass through its own 2-flop synchronizer.
REQ-013 Each synchronized input SHALL have its own debouncer: counter increments each cycle the synchronized value differs from the debounced value, clears on any cycle they match.
REQ-014 Debounced value SHALL take the synchronized value on the cycle the counter reaches DEB_CYCLES-1 while still differing; counter clears that cycle.
REQ-015 Quadrature state is {A,B} debounced; detent state is 11.
REQ-016 Clockwise sequence SHALL be 11->01->00->10->11; counter-clockwise is the reverse.
REQ-017 A signed step accumulator (range -4..+4) SHALL add +1 per clockwise single-bit transition, -1 per counter-clockwise one.
REQ-018 Transition where both A and B change in one debounced update: accumulator unchanged, err pulses one cycle.
REQ-019 On entry to state 11: accumulator +4 -> cw pulse; -4 -> ccw pulse; any other value -> no pulse; accumulator clears to 0 in all cases.
REQ-020 Back-and-forth jitter (e.g. 11->01->11) SHALL produce no pulse and leave accumulator at 0.
REQ-021 Accumulator SHALL saturate at +4/-4, never wrap.
REQ-022 btn SHALL pulse one cycle on debounced sw_n falling edge (1->0); release produces no pulse.
REQ-023 cw, ccw, btn, err SHALL be registered, asserted the cycle after the causing debounced change.
REQ-024 cw and ccw SHALL never assert in the same cycle; btn is independent and may coincide with either.
REQ-025 Pin-to-pulse latency SHALL be exactly 2 + DEB_CYCLES + 1 cycles for an input held stable after its final edge.
REQ-026 Held switch or parked encoder SHALL produce no further pulses.

Reset
REQ-027 While rst_n=0 at a clock edge: synchronizer flops and debounced values set to 1, debounce counters and accumulator to 0, cw/ccw/btn/err to 0.
REQ-028 Reset mid-rotation SHALL discard partial steps; first detent after reset starts a fresh count from 0.
REQ-029 Reset release with sw_n already 0 SHALL produce one btn pulse after full debounce latency (debounced starts at 1).

Verification (DEB_CYCLES=4)
REQ-030 Reset, then A/B driven 11->01->00->10->11, each step held 10 cycles -> exactly one cw pulse, 7 cycles after final step edge; ccw, err stay 0.
REQ-031 Reverse sequence 11->10->00->01->11 -> exactly one ccw pulse; cw stays 0.
REQ-032 sw_n low 3 cycles, high 2, low 20 -> exactly one btn pulse 7 cycles after last falling edge; release produces none.
REQ-033 A/B 11->00 in one step, held 10 cycles -> one err pulse, no cw/ccw; accumulator 0 after return to 11.
REQ-034 Two cw steps (11->01->00), rst_n low 2 cycles, then full ccw sequence -> only one ccw pulse, no cw.
REQ-035 Jitter 11->01->11 repeated 5 times -> no cw/ccw/err pulses.
